piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out serializer for the SerDes transmit path. It accepts DATA_W-bit words over a valid/ready handshake and streams them one bit per clock. A one-word holding buffer lets back-to-back words serialize with no idle cycles. Bit order is configurable, and an optional parity bit can follow each word. The block sits between the encoder/framer and the line driver.

---
 rtl/serdes_pkg.sv | 17 +
 rtl/piso_serializer_if.sv | 24 ++
 rtl/piso_hold_buf.sv | 37 +++
 rtl/piso_serializer.sv | 128 ++++++++++++
 tb/tb_piso_serializer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared serializer state encoding and parity helper
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PAR_MAX_W = 64;

  // Even parity over a zero-extended word; words wider than PAR_MAX_W are not supported.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel word input and serial bit output bundle
interface piso_serializer_if #(
  parameter int DATA_W = 10
);

  logic [DATA_W-1:0] par_in;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              word_start;
  logic              busy;

  modport master (
    output par_in, in_valid,
    input  in_ready, ser_out, ser_valid, word_start, busy
  );

  modport slave (
    input  par_in, in_valid,
    output in_ready, ser_out, ser_valid, word_start, busy
  );

endinterface

// File: rtl/piso_hold_buf.sv
// rtl/piso_hold_buf.sv - single-entry holding buffer that owns hold_full and in_ready
module piso_hold_buf #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_full_nxt,
  output logic              o_in_ready
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (i_wr) begin
        r_data <= i_wdata;
      end
      r_full <= o_full_nxt;
    end
  end

  assign o_full_nxt = i_wr | (r_full & ~i_rd);
  assign o_full     = r_full;
  assign o_rdata    = r_data;
  // Gated by rst_n so no word is taken while reset is asserted.
  assign o_in_ready = rst_n & ~r_full;

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out serializer, optional parity via PISO_PARITY_EN
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int   DATA_W    = 10,
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  piso_serializer_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  piso_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_ser_out, w_ser_nxt;
  logic              r_ser_valid, w_valid_nxt;
  logic              r_word_start, w_ws_nxt;
  logic              r_busy;

  logic              w_in_ready, w_hold_full, w_hold_full_nxt;
  logic [DATA_W-1:0] w_hold_data, w_load_word, w_load_rest, w_shift_rest;
  logic              w_load_first, w_shift_first;
  logic              w_accept, w_last, w_needs, w_rd, w_bypass, w_wr, w_load;

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_last   = (r_state == DATA) && (r_cnt == CNT_W'(DATA_W - 1));
`ifdef PISO_PARITY_EN
  logic r_par, w_par_nxt;
  assign w_needs = (r_state == IDLE) || (r_state == PARITY);
`else
  assign w_needs = (r_state == IDLE) || w_last;
`endif
  assign w_rd     = w_needs & w_hold_full;
  assign w_bypass = w_needs & ~w_hold_full & w_accept;
  assign w_wr     = w_accept & ~w_bypass;
  assign w_load   = w_rd | w_bypass;

  assign w_load_word   = w_hold_full ? w_hold_data : bus.par_in;
  assign w_load_first  = MSB_FIRST ? w_load_word[DATA_W-1] : w_load_word[0];
  assign w_load_rest   = MSB_FIRST ? {w_load_word[DATA_W-2:0], 1'b0} : {1'b0, w_load_word[DATA_W-1:1]};
  assign w_shift_first = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
  assign w_shift_rest  = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0} : {1'b0, r_shift[DATA_W-1:1]};

  piso_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr       (w_wr),
    .i_rd       (w_rd),
    .i_wdata    (bus.par_in),
    .o_rdata    (w_hold_data),
    .o_full     (w_hold_full),
    .o_full_nxt (w_hold_full_nxt),
    .o_in_ready (w_in_ready)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_ser_nxt   = r_ser_out;
    w_valid_nxt = r_ser_valid;
    w_ws_nxt    = 1'b0;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_load) begin
      w_state_nxt = DATA;
      w_cnt_nxt   = '0;
      w_ser_nxt   = w_load_first;
      w_shift_nxt = w_load_rest;
      w_valid_nxt = 1'b1;
      w_ws_nxt    = 1'b1;
`ifdef PISO_PARITY_EN
      w_par_nxt   = even_parity(PAR_MAX_W'(w_load_word));
`endif
    end else if (w_needs) begin
      w_state_nxt = IDLE;
      w_ser_nxt   = IDLE_LVL;
      w_valid_nxt = 1'b0;
`ifdef PISO_PARITY_EN
    end else if (w_last) begin
      w_state_nxt = PARITY;
      w_ser_nxt   = r_par;
`endif
    end else begin
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_ser_nxt   = w_shift_first;
      w_shift_nxt = w_shift_rest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_ser_out    <= IDLE_LVL;
      r_ser_valid  <= 1'b0;
      r_word_start <= 1'b0;
      r_busy       <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_ser_out    <= w_ser_nxt;
      r_ser_valid  <= w_valid_nxt;
      r_word_start <= w_ws_nxt;
      r_busy       <= (w_state_nxt != IDLE) | w_hold_full_nxt;
`ifdef PISO_PARITY_EN
      r_par        <= w_par_nxt;
`endif
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.ser_out    = r_ser_out;
  assign bus.ser_valid  = r_ser_valid;
  assign bus.word_start = r_word_start;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer (LSB- and MSB-first instances)
module tb_piso_serializer;

  localparam int DW = 10;
`ifdef PISO_PARITY_EN
  localparam int PW = DW + 1;
`else
  localparam int PW = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tb_valid = 1'b0;
  logic [DW-1:0] tb_par = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.DATA_W(DW)) ifa ();
  piso_serializer_if #(.DATA_W(DW)) ifb ();

  assign ifa.in_valid = tb_valid;
  assign ifa.par_in   = tb_par;
  assign ifb.in_valid = tb_valid;
  assign ifb.par_in   = tb_par;

  piso_serializer #(.DATA_W(DW), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  piso_serializer #(.DATA_W(DW), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  function automatic logic exp_bit(input bit msb, input logic [DW-1:0] w, input int i);
    if (i >= DW) return ^w;
    return msb ? w[DW-1-i] : w[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic [DW-1:0] w, input int i);
    chk({tag, " lsb ser_out"},    ifa.ser_out,    exp_bit(1'b0, w, i));
    chk({tag, " msb ser_out"},    ifb.ser_out,    exp_bit(1'b1, w, i));
    chk({tag, " lsb ser_valid"},  ifa.ser_valid,  1'b1);
    chk({tag, " msb ser_valid"},  ifb.ser_valid,  1'b1);
    chk({tag, " lsb word_start"}, ifa.word_start, (i == 0));
    chk({tag, " msb word_start"}, ifb.word_start, (i == 0));
    chk({tag, " lsb busy"},       ifa.busy,       1'b1);
  endtask

  task automatic chk_idle(input string tag, input logic exp_ready);
    chk({tag, " lsb ser_out"},    ifa.ser_out,    1'b0);
    chk({tag, " msb ser_out"},    ifb.ser_out,    1'b0);
    chk({tag, " lsb ser_valid"},  ifa.ser_valid,  1'b0);
    chk({tag, " msb ser_valid"},  ifb.ser_valid,  1'b0);
    chk({tag, " lsb word_start"}, ifa.word_start, 1'b0);
    chk({tag, " lsb busy"},       ifa.busy,       1'b0);
    chk({tag, " msb busy"},       ifb.busy,       1'b0);
    chk({tag, " lsb in_ready"},   ifa.in_ready,   exp_ready);
    chk({tag, " msb in_ready"},   ifb.in_ready,   exp_ready);
  endtask

  task automatic send_single(input string tag, input logic [DW-1:0] w);
    tb_par   = w;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    for (int i = 0; i < PW; i++) begin
      chk_slot($sformatf("%s bit%0d", tag, i), w, i);
      tick();
    end
    chk_idle({tag, " after"}, 1'b1);
  endtask

  logic [DW-1:0] bw [3];
  logic [DW-1:0] w301;
  int            k;
  logic          acc;

  initial begin
    bw[0] = 10'h301;
    bw[1] = 10'h0FF;
    bw[2] = 10'h155;
    w301  = 10'h301;

    // Reset held: outputs at reset values, in_ready forced low
    repeat (3) tick();
    chk_idle("in_reset", 1'b0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_idle($sformatf("idle%0d", c), 1'b1);
    end

    // Hand vectors for 10'h301: LSB 1,0,0,0,0,0,0,0,1,1 and MSB 1,1,0,0,0,0,0,0,0,1
    tb_par   = w301;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    for (int i = 0; i < DW; i++) begin
      chk($sformatf("h301 lsb vec%0d", i), ifa.ser_out, (i == 0 || i == 8 || i == 9));
      chk($sformatf("h301 msb vec%0d", i), ifb.ser_out, (i == 0 || i == 1 || i == 9));
      chk($sformatf("h301 ws%0d", i), ifa.word_start, (i == 0));
      tick();
    end
`ifdef PISO_PARITY_EN
    chk("h301 parity lsb", ifa.ser_out, 1'b1);
    chk("h301 parity msb", ifb.ser_out, 1'b1);
    chk("h301 parity valid", ifa.ser_valid, 1'b1);
    chk("h301 parity ws", ifa.word_start, 1'b0);
    tick();
`endif
    chk_idle("h301 after", 1'b1);

    send_single("h0FF", 10'h0FF);
    send_single("h2AA", 10'h2AA);

    // Back-to-back with in_valid held high
    k        = 0;
    tb_par   = bw[0];
    tb_valid = 1'b1;
    for (int t = 0; t < 3 * PW; t++) begin
      acc = tb_valid & ifa.in_ready;
      tick();
      if (acc) begin
        k++;
        if (k < 3) tb_par = bw[k];
        else tb_valid = 1'b0;
      end
      chk_slot($sformatf("b2b t%0d", t), bw[t / PW], t % PW);
      chk($sformatf("b2b in_ready t%0d", t), ifa.in_ready, ((t % PW) == 0) || (t >= 2 * PW));
    end
    tick();
    chk_idle("b2b after", 1'b1);
    chk("b2b accepted words", k, 3);

    // Reset at bit 4 with hold full; hold contents must be discarded
    tb_par   = w301;
    tb_valid = 1'b1;
    tick();
    tb_par = 10'h0FF;
    tick();
    tb_valid = 1'b0;
    chk("rst hold full in_ready", ifa.in_ready, 1'b0);
    repeat (3) tick();
    chk_slot("rst pre bit4", w301, 4);
    rst_n = 1'b0;
    #1;
    chk_idle("rst async", 1'b0);
    tick();
    chk_idle("rst held", 1'b0);
    #2 rst_n = 1'b1;
    #1;
    chk("rst release in_ready", ifa.in_ready, 1'b1);
    tick();
    send_single("post_rst h001", 10'h001);
    repeat (PW + 2) begin
      tick();
      chk_idle("post_rst quiet", 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
